mips_pipe: RTL and testbench
============================

MIPS_PIPE -- requirements
Module: mips_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 16, datapath and register width (8..32).
REQ-002 SHALL have parameter NREG, default 8, number of architectural registers (2..32), addressed 0..NREG-1.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 in_valid  input  1  instruction present this cycle.
REQ-007 instruction  input  32  MIPS-format instruction word.
REQ-008 out_valid  output  1  one result per accepted instruction.
REQ-009 instruction_fail  output  1  accepted instruction was illegal; qualified by out_valid.
REQ-010 wb_addr  output  5  destination register of reported instruction.
REQ-011 wb_data  output  DATA_W  value written (0 on fail).
REQ-012 regs  output  DATA_W*NREG  flat register file, register k at bits [k*DATA_W +: DATA_W].

Function
REQ-013 SHALL accept one instruction every cycle in_valid=1; no backpressure.
REQ-014 SHALL be two-stage: decode/operand read at edge E0 (sampling in_valid), execute/writeback at E1; out_valid, wb_* and regs update visible after E1.
REQ-015 R-type (opcode 000000) SHALL support funct add 100000, sub 100010, and 100100, or 100101, nor 100111, slt 101010 (signed), sll 000000, srl 000010, sra 000011; dest = rd, shift amount = shamt.
REQ-016 I-type SHALL support addi 001000 (sign-extended imm), andi 001100 and ori 001101 (zero-extended imm); dest = rt.
REQ-017 Arithmetic SHALL wrap modulo 2^DATA_W; immediates truncated to DATA_W after extension.
REQ-018 Shifts with shamt >= DATA_W SHALL give 0 (sll/srl) or all sign bits (sra).
REQ-019 Register 0 SHALL read as 0; writes to it SHALL be discarded without fail.
REQ-020 instruction_fail SHALL be 1 for unknown opcode, unknown funct, or any used source/dest address >= NREG; failed instructions SHALL not modify regs.
REQ-021 Back-to-back dependency: an instruction reading the register written by the immediately preceding instruction SHALL see the new value (execute-to-decode bypass); bypass SHALL not apply to failed or reg-0 writes.
REQ-022 When out_valid=0, out_valid, instruction_fail, wb_addr, wb_data SHALL be 0; regs SHALL hold (persistent, not cleared between bursts).
REQ-023 Gaps in in_valid SHALL produce matching gaps in out_valid, in order, no reordering.

Reset
REQ-024 Asserting rst at any time SHALL immediately clear regs, pipeline valid, and all outputs to 0; an instruction in flight SHALL be dropped.
REQ-025 First instruction SHALL be accepted on the first edge with rst=0 and in_valid=1.

Structure
REQ-026 Opcode/funct constants, ALU op enum and a decoded-instruction struct SHALL live in package mips_pipe_pkg.
REQ-027 The combinational ALU SHALL be sub-module mips_pipe_alu (parameter DATA_W; inputs op, a, b, shamt; output y).
REQ-028 Register file SHALL be flip-flops inside mips_pipe; no memory macro.

Verification
REQ-029 Reset, then addi r1,r0,0x7FFF at cycle 0 -> out_valid=1 at cycle 2, wb_addr=1, wb_data=0x7FFF, regs[1]=0x7FFF.
REQ-030 addi r1,r0,5 then add r2,r1,r1 in consecutive cycles -> second result wb_data=10 (bypass); regs[2]=10.
REQ-031 addi r3,r0,0x8000 then sra r4,r3,shamt 20 -> wb_data=0xFFFF; srl same -> 0.
REQ-032 opcode 000100, then add r9,... with NREG=8 -> both instruction_fail=1, wb_data=0, regs unchanged.
REQ-033 addi r0,r0,7 -> instruction_fail=0, regs[0]=0; following add r1,r0,r0 -> 0.
REQ-034 rst asserted mid-stream with two instructions in flight -> no out_valid afterwards, regs all 0.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared decode constants, ALU operation set and the instruction decoder.
package mips_pipe_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR,
    ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_e;

  typedef struct packed {
    logic       fail;
    alu_op_e    op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dest;
    logic [4:0] shamt;
    logic       use_imm;
    logic [31:0] imm;
  } dec_t;

  // True when a register address lies outside the implemented file.
  function automatic logic addr_bad(input logic [4:0] a, input int unsigned nreg);
    return 32'(a) >= nreg;
  endfunction

  // Decode one instruction word; address range errors fold into fail.
  function automatic dec_t decode(input logic [31:0] instr, input int unsigned nreg);
    dec_t d;
    logic uses_rs;
    d         = '0;
    d.op      = ALU_ADD;
    d.rs      = instr[25:21];
    d.rt      = instr[20:16];
    d.dest    = instr[20:16];
    d.shamt   = instr[10:6];
    uses_rs   = 1'b1;
    unique case (instr[31:26])
      OP_RTYPE: begin
        d.dest = instr[15:11];
        unique case (instr[5:0])
          FN_ADD:  d.op = ALU_ADD;
          FN_SUB:  d.op = ALU_SUB;
          FN_AND:  d.op = ALU_AND;
          FN_OR:   d.op = ALU_OR;
          FN_NOR:  d.op = ALU_NOR;
          FN_SLT:  d.op = ALU_SLT;
          FN_SLL:  begin d.op = ALU_SLL; uses_rs = 1'b0; end
          FN_SRL:  begin d.op = ALU_SRL; uses_rs = 1'b0; end
          FN_SRA:  begin d.op = ALU_SRA; uses_rs = 1'b0; end
          default: d.fail = 1'b1;
        endcase
      end
      OP_ADDI: begin
        d.op      = ALU_ADD;
        d.use_imm = 1'b1;
        d.imm     = {{16{instr[15]}}, instr[15:0]};
      end
      OP_ANDI: begin
        d.op      = ALU_AND;
        d.use_imm = 1'b1;
        d.imm     = {16'h0000, instr[15:0]};
      end
      OP_ORI: begin
        d.op      = ALU_OR;
        d.use_imm = 1'b1;
        d.imm     = {16'h0000, instr[15:0]};
      end
      default: d.fail = 1'b1;
    endcase
    // rt is either a source (R-type) or the destination (I-type), so it is always checked
    if ((uses_rs && addr_bad(d.rs, nreg)) || addr_bad(d.rt, nreg) || addr_bad(d.dest, nreg))
      d.fail = 1'b1;
    return d;
  endfunction

endpackage

// File: rtl/mips_pipe_alu.sv
// Combinational ALU: arithmetic wraps, oversized shifts saturate to 0 or sign fill.
module mips_pipe_alu
  import mips_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  alu_op_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [4:0]        shamt,
  output logic [DATA_W-1:0] y
);

  localparam logic [5:0] W6 = 6'(DATA_W);

  logic shift_all;
  assign shift_all = {1'b0, shamt} >= W6;

  // Select the result for the requested operation; shifts act on b.
  always_comb begin
    y = '0;
    unique case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_NOR: y = ~(a | b);
      ALU_SLT: y[0] = $signed(a) < $signed(b);
      ALU_SLL: y = shift_all ? '0 : (b << shamt);
      ALU_SRL: y = shift_all ? '0 : (b >> shamt);
      ALU_SRA: y = shift_all ? {DATA_W{b[DATA_W-1]}} : DATA_W'($signed(b) >>> shamt);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/mips_pipe.sv
// Two-stage MIPS subset pipeline: decode/operand read, then execute/writeback.
module mips_pipe
  import mips_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREG   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [31:0]            instruction,
  output logic                   out_valid,
  output logic                   instruction_fail,
  output logic [4:0]             wb_addr,
  output logic [DATA_W-1:0]      wb_data,
  output logic [DATA_W*NREG-1:0] regs
);

  localparam int unsigned AW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [DATA_W-1:0] rf [NREG];

  dec_t              dec;
  logic [DATA_W-1:0] rs_val, rt_val, op_b;
  logic              unused_imm;

  logic              ex_valid;
  logic              ex_fail;
  alu_op_e           ex_op;
  logic [4:0]        ex_dest;
  logic [4:0]        ex_shamt;
  logic [DATA_W-1:0] ex_a, ex_b;
  logic [DATA_W-1:0] alu_y;
  logic              ex_wr;

  assign dec        = decode(instruction, NREG);
  assign unused_imm = ^dec.imm;
  assign ex_wr      = ex_valid && !ex_fail && (ex_dest != 5'd0);

  // Operand read with bypass from the instruction retiring on the same edge.
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (dec.rs != 5'd0 && !addr_bad(dec.rs, NREG)) rs_val = rf[dec.rs[AW-1:0]];
    if (dec.rt != 5'd0 && !addr_bad(dec.rt, NREG)) rt_val = rf[dec.rt[AW-1:0]];
    if (ex_wr && ex_dest == dec.rs) rs_val = alu_y;
    if (ex_wr && ex_dest == dec.rt) rt_val = alu_y;
    op_b = dec.use_imm ? dec.imm[DATA_W-1:0] : rt_val;
  end

  // Decode stage register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_fail  <= 1'b0;
      ex_op    <= ALU_ADD;
      ex_dest  <= '0;
      ex_shamt <= '0;
      ex_a     <= '0;
      ex_b     <= '0;
    end else begin
      ex_valid <= in_valid;
      ex_fail  <= dec.fail;
      ex_op    <= dec.op;
      ex_dest  <= dec.dest;
      ex_shamt <= dec.shamt;
      ex_a     <= rs_val;
      ex_b     <= op_b;
    end
  end

  mips_pipe_alu #(.DATA_W(DATA_W)) u_alu (
    .op    (ex_op),
    .a     (ex_a),
    .b     (ex_b),
    .shamt (ex_shamt),
    .y     (alu_y)
  );

  // Execute/writeback: report every valid instruction, commit only legal non-r0 writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid        <= 1'b0;
      instruction_fail <= 1'b0;
      wb_addr          <= '0;
      wb_data          <= '0;
      for (int unsigned k = 0; k < NREG; k++) rf[k] <= '0;
    end else begin
      out_valid        <= 1'b0;
      instruction_fail <= 1'b0;
      wb_addr          <= '0;
      wb_data          <= '0;
      if (ex_valid) begin
        out_valid        <= 1'b1;
        instruction_fail <= ex_fail;
        wb_addr          <= ex_dest;
        wb_data          <= ex_fail ? '0 : alu_y;
      end
      if (ex_wr) rf[ex_dest[AW-1:0]] <= alu_y;
    end
  end

  // Flatten the register file onto the output bus.
  always_comb begin
    regs = '0;
    for (int unsigned k = 0; k < NREG; k++) regs[k*DATA_W +: DATA_W] = rf[k];
  end

endmodule

// File: tb/tb_mips_pipe.sv
// Randomized bench for mips_pipe against a sequential architectural model.
module tb_mips_pipe;

  localparam int DW = 16;
  localparam int NR = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [31:0]       instruction = '0;
  logic              out_valid;
  logic              instruction_fail;
  logic [4:0]        wb_addr;
  logic [DW-1:0]     wb_data;
  logic [DW*NR-1:0]  regs;

  mips_pipe #(.DATA_W(DW), .NREG(NR)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .instruction      (instruction),
    .out_valid        (out_valid),
    .instruction_fail (instruction_fail),
    .wb_addr          (wb_addr),
    .wb_data          (wb_data),
    .regs             (regs)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic        f;
    logic [4:0]  a;
    logic [15:0] d;
  } exp_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] mregs [32];
  exp_t        prev = '0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(int rs, int rt, int rd, int sh, logic [5:0] fn);
    return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] itype(logic [5:0] op, int rs, int rt, logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [15:0] getr(int k);
    return regs[k*DW +: DW];
  endfunction

  function automatic logic [127:0] model_flat();
    logic [127:0] f;
    for (int k = 0; k < NR; k++) f[k*16 +: 16] = mregs[k];
    return f;
  endfunction

  function automatic logic [15:0] rdm(int i);
    return (i == 0 || i >= NR) ? 16'h0 : mregs[i];
  endfunction

  // Architectural semantics: each instruction sees all earlier results.
  task automatic model(input logic [31:0] ins, output exp_t e);
    int rs, rt, rd, sh, dest, sb;
    logic [15:0] A, B, val;
    bit fail, urs;
    rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]); sh = int'(ins[10:6]);
    A = rdm(rs); B = rdm(rt);
    sb = int'($signed(B));
    fail = 0; urs = 1; val = 0; dest = rt;
    case (ins[31:26])
      6'b000000: begin
        dest = rd;
        case (ins[5:0])
          6'h20: val = 16'(int'(A) + int'(B));
          6'h22: val = 16'(int'(A) - int'(B));
          6'h24: val = A & B;
          6'h25: val = A | B;
          6'h27: val = ~(A | B);
          6'h2A: val = (int'($signed(A)) < sb) ? 16'd1 : 16'd0;
          6'h00: begin urs = 0; val = 16'(int'(B) << sh); end
          6'h02: begin urs = 0; val = 16'(int'(B) >> sh); end
          6'h03: begin urs = 0; val = 16'(sb >>> sh); end
          default: fail = 1;
        endcase
      end
      6'b001000: val = 16'(int'(A) + int'($signed(ins[15:0])));
      6'b001100: val = A & ins[15:0];
      6'b001101: val = A | ins[15:0];
      default:   fail = 1;
    endcase
    if ((urs && rs >= NR) || rt >= NR || dest >= NR) fail = 1;
    if (!fail && dest != 0) mregs[dest] = val;
    e.v = 1'b1;
    e.f = fail;
    e.a = 5'(dest);
    e.d = fail ? 16'h0 : val;
  endtask

  // Apply one cycle of input, then check what the previous cycle's instruction produced.
  task automatic step(input bit v, input logic [31:0] ins);
    exp_t e;
    logic [127:0] snap;
    snap = model_flat();
    e = '0;
    if (v) model(ins, e);
    in_valid = v;
    instruction = ins;
    @(posedge clk);
    #1;
    check("out_valid", 128'(out_valid), 128'(prev.v));
    check("instruction_fail", 128'(instruction_fail), 128'(prev.f));
    if (!prev.v) check("wb_addr_idle", 128'(wb_addr), 128'(0));
    else if (!prev.f) check("wb_addr", 128'(wb_addr), 128'(prev.a));
    check("wb_data", 128'(wb_data), 128'(prev.d));
    check("regs", 128'(regs), snap);
    prev = e;
  endtask

  task automatic model_clear();
    for (int k = 0; k < 32; k++) mregs[k] = '0;
    prev = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    instruction = '0;
    #2;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_wb_data", 128'(wb_data), 128'(0));
    check("rst_regs", 128'(regs), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  function automatic int rsel();
    return ($urandom_range(0, 15) == 0) ? int'($urandom_range(8, 31)) : int'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] rand_ins();
    logic [5:0] fns [9];
    int k;
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h03};
    k = int'($urandom_range(0, 12));
    if (k < 9) return rtype(rsel(), rsel(), rsel(), int'($urandom_range(0, 31)), fns[k]);
    if (k == 9)  return itype(6'b001000, rsel(), rsel(), 16'($urandom));
    if (k == 10) return itype(6'b001100, rsel(), rsel(), 16'($urandom));
    if (k == 11) return itype(6'b001101, rsel(), rsel(), 16'($urandom));
    return ($urandom_range(0, 1) == 0) ? itype(6'b000100, rsel(), rsel(), 16'($urandom))
                                       : rtype(rsel(), rsel(), rsel(), 0, 6'b000001);
  endfunction

  initial begin
    model_clear();
    do_reset();

    // addi r1,r0,0x7FFF: result two edges after issue
    step(1, itype(6'b001000, 0, 1, 16'h7FFF));
    check("r029_early_valid", 128'(out_valid), 128'(0));
    step(0, '0);
    check("r029_valid", 128'(out_valid), 128'(1));
    check("r029_addr", 128'(wb_addr), 128'(1));
    check("r029_data", 128'(wb_data), 128'(16'h7FFF));
    check("r029_reg1", 128'(getr(1)), 128'(16'h7FFF));

    // back-to-back dependency through the bypass
    step(1, itype(6'b001000, 0, 1, 16'd5));
    step(1, rtype(1, 1, 2, 0, 6'h20));
    step(0, '0);
    check("r030_data", 128'(wb_data), 128'(10));
    check("r030_reg2", 128'(getr(2)), 128'(10));

    // oversized shifts on a negative value
    step(1, itype(6'b001000, 0, 3, 16'h8000));
    step(1, rtype(0, 3, 4, 20, 6'h03));
    step(1, rtype(0, 3, 5, 20, 6'h02));
    check("r031_sra", 128'(wb_data), 128'(16'hFFFF));
    step(0, '0);
    check("r031_srl", 128'(wb_data), 128'(0));
    check("r031_reg4", 128'(getr(4)), 128'(16'hFFFF));

    // illegal opcode and out-of-range register
    step(1, itype(6'b000100, 1, 2, 16'h0003));
    step(1, rtype(1, 1, 9, 0, 6'h20));
    check("r032_fail_op", 128'(instruction_fail), 128'(1));
    step(0, '0);
    check("r032_fail_reg", 128'(instruction_fail), 128'(1));
    check("r032_data", 128'(wb_data), 128'(0));

    // writes to r0 are silently discarded
    step(1, itype(6'b001000, 0, 0, 16'd7));
    step(1, rtype(0, 0, 1, 0, 6'h20));
    check("r033_fail", 128'(instruction_fail), 128'(0));
    check("r033_reg0", 128'(getr(0)), 128'(0));
    step(0, '0);
    check("r033_add", 128'(wb_data), 128'(0));

    // reset with instructions in flight
    step(1, itype(6'b001000, 0, 6, 16'd11));
    step(1, itype(6'b001000, 0, 7, 16'd12));
    in_valid = 1'b1;
    instruction = itype(6'b001101, 0, 5, 16'h00AA);
    #2;
    rst = 1'b1;
    #1;
    check("r034_valid_now", 128'(out_valid), 128'(0));
    check("r034_regs_now", 128'(regs), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    for (int i = 0; i < 3; i++) step(0, '0);

    // randomized traffic with gaps
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) step(0, '0);
      else step(1, rand_ins());
    end
    step(0, '0);
    step(0, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
